fetch_redirect_unit: RTL
========================

Name: fetch_redirect_unit

Overview:
- Fetch-stage PC register and next-PC selection for the 5-stage pipeline, directly downstream of the execute-stage branch decision.
- Consumes NeedBranchE and the jump indication, redirects fetch to PCTargetE, and generates the D/E flushes for the two wrong-path instructions.
- Holds PC on load-use stall.
- Halts fetch permanently on a misaligned redirect target.

Parameters:
- XLEN, 32, PC width in bits.
- RESET_VECTOR, 32'h0000_0000, PC loaded on reset (XLEN bits).

Ports:
- clk  input  1  core clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- StallF  input  1  hazard-unit stall: hold PCF.
- BranchE  input  1  conditional branch present in E (taken or not).
- NeedBranchE  input  1  conditional branch in E is taken.
- JumpE  input  1  JAL/JALR in E.
- PCTargetE  input  XLEN  resolved target from E.
- PCF  output  XLEN  current fetch address.
- PCPlus4F  output  XLEN  PCF + 4.
- FetchValidF  output  1  PCF is a real fetch this cycle.
- FlushD  output  1  squash IF/ID register.
- FlushE  output  1  squash ID/EX register.
- HaltedF  output  1  fetch halted on misaligned target.

Behaviour:
- Reset is asynchronous on reset_n low; nothing waits for a clock edge.
  - PCF = RESET_VECTOR.
  - state = BOOT.
  - FetchValidF = 0, FlushD = 0, FlushE = 0, HaltedF = 0.
  - Perf counters (if built) = 0.
- State machine has three states: BOOT, RUN, HALT.
- BOOT:
  - Lasts exactly one clock after reset_n rises.
  - PCF held at RESET_VECTOR, FetchValidF = 0, all E-stage inputs ignored.
  - Goes to RUN unconditionally.
- RUN:
  - FetchValidF = 1.
  - redirect = NeedBranchE | JumpE.
  - misalign = redirect & (PCTargetE[1:0] != 2'b00).
  - redirect & !misalign:
    - PCF <= PCTargetE at the next edge.
    - FlushD = 1 and FlushE = 1 combinationally in the same cycle.
    - Redirect takes priority over StallF.
  - misalign:
    - Go to HALT. PCF is not updated.
    - FlushD = 1 and FlushE = 1 this cycle.
  - !redirect & StallF: PCF holds, no flush.
  - Otherwise PCF <= PCPlus4F.
- HALT:
  - FetchValidF = 0, HaltedF = 1, FlushD = 1, FlushE = 0.
  - PCF frozen; all inputs ignored.
  - Exit only via reset_n.
- Arithmetic: PCPlus4F = PCF + 4, modulo 2^XLEN; all-ones minus 3 wraps to 0 with no flag.
- Latency: the redirect decision made in cycle N appears on PCF in cycle N+1. Exactly two instructions are squashed, via FlushD/FlushE in cycle N.
- Simultaneous NeedBranchE and JumpE: treated as a single redirect to PCTargetE.
- FlushD/FlushE/HaltedF/FetchValidF are pure functions of state and current inputs; there is no registered delay.
- Reset asserted mid-redirect: reset wins immediately and the pending redirect is lost.

Optional Feature:
- Macro: BRANCH_PERF_CNT_EN.
- When defined, two ports are added:
  - BranchCountF, output, 32 bits.
  - TakenCountF, output, 32 bits.
- Counting rules (RUN only, including the cycle that goes to HALT):
  - BranchCountF increments each cycle BranchE = 1.
  - TakenCountF increments each cycle redirect = 1.
  - Both saturate at 32'hFFFF_FFFF.
  - Both are reset to 0 by reset_n.
- When not defined:
  - The ports and counters do not exist.
  - All other behaviour is identical.

Test Plan:
- Reset then idle:
  - Release reset_n; FetchValidF = 0 for one cycle with PCF = 0x0.
  - PCF then reads 0x0, 0x4, 0x8, 0xC on successive cycles.
- Taken branch:
  - At PCF = 0x10, pulse NeedBranchE = 1 with PCTargetE = 0x100 for one cycle.
  - Same cycle: FlushD = FlushE = 1. Next cycle: PCF = 0x100. Following cycle: PCF = 0x104.
- Stall vs. redirect:
  - Hold StallF = 1 for 3 cycles at PCF = 0x20; PCF stays 0x20 with no flush.
  - Then StallF = 1 together with JumpE = 1 and PCTargetE = 0x40; next PCF = 0x40.
- Misaligned target:
  - JumpE = 1 with PCTargetE = 0x102; next cycle HaltedF = 1 and FetchValidF = 0.
  - PCF keeps its pre-jump value through 10 more cycles of random inputs.
  - Pulse reset_n low; PCF = 0x0 and state returns to BOOT.
- Wrap-around:
  - RESET_VECTOR = 32'hFFFF_FFF8; after BOOT, PCF reads FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Perf counters (macro defined):
  - 5 cycles with BranchE = 1, 2 of them with NeedBranchE = 1, plus 1 JumpE.
  - Expect BranchCountF = 5 and TakenCountF = 3.
  - Force the counters near the maximum and confirm they stick at FFFF_FFFF.

Source files
------------

// File: rtl/fetch_redirect_unit.sv
// Fetch-stage PC register with execute-stage redirect, load-use hold and misaligned-target halt.
// Optional branch/taken performance counters are built when BRANCH_PERF_CNT_EN is defined.
module fetch_redirect_unit #(
  parameter int unsigned      XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            StallF,
  input  logic            BranchE,
  input  logic            NeedBranchE,
  input  logic            JumpE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic [XLEN-1:0] PCF,
  output logic [XLEN-1:0] PCPlus4F,
  output logic            FetchValidF,
  output logic            FlushD,
  output logic            FlushE,
  output logic            HaltedF
`ifdef BRANCH_PERF_CNT_EN
  ,
  output logic [31:0]     BranchCountF,
  output logic [31:0]     TakenCountF
`endif
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_pc;

  logic            w_run;
  logic            w_halt;
  logic            w_redirect;
  logic            w_misalign;
  logic [XLEN-1:0] w_pc_plus4;

  assign w_run      = (r_state == ST_RUN);
  assign w_halt     = (r_state == ST_HALT);
  assign w_redirect = NeedBranchE | JumpE;
  assign w_misalign = w_redirect & (PCTargetE[1:0] != 2'b00);
  assign w_pc_plus4 = r_pc + XLEN'(4);

  // Redirect outranks stall; a misaligned target parks fetch until reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_BOOT;
      r_pc    <= RESET_VECTOR;
    end else begin
      case (r_state)
        ST_BOOT: r_state <= ST_RUN;
        ST_RUN: begin
          if (w_misalign) begin
            r_state <= ST_HALT;
          end else if (w_redirect) begin
            r_pc <= PCTargetE;
          end else if (!StallF) begin
            r_pc <= w_pc_plus4;
          end
        end
        ST_HALT: r_state <= ST_HALT;
        default: r_state <= ST_HALT;
      endcase
    end
  end

  // Flush/valid/halt must react in the same cycle as the E-stage decision.
  assign PCF         = r_pc;
  assign PCPlus4F    = w_pc_plus4;
  assign FetchValidF = w_run;
  assign FlushD      = (w_run & w_redirect) | w_halt;
  assign FlushE      = w_run & w_redirect;
  assign HaltedF     = w_halt;

`ifdef BRANCH_PERF_CNT_EN
  logic [31:0] r_branch_cnt;
  logic [31:0] r_taken_cnt;

  // Saturating event counters, active only while running.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_branch_cnt <= '0;
      r_taken_cnt  <= '0;
    end else begin
      if (w_run && BranchE && (r_branch_cnt != '1)) begin
        r_branch_cnt <= r_branch_cnt + 32'(1);
      end
      if (w_run && w_redirect && (r_taken_cnt != '1)) begin
        r_taken_cnt <= r_taken_cnt + 32'(1);
      end
    end
  end

  assign BranchCountF = r_branch_cnt;
  assign TakenCountF  = r_taken_cnt;
`endif

endmodule
